// File: rtl/fir_out_decim.sv
// Decimating output stage for the FIR: keep one of every DECIM samples, round/shift/saturate
// to 8-bit signed, and buffer the results in a small FWFT FIFO read with valid/ready.
module fir_out_decim #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] y_in,
    input  logic        in_en,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        sat_flag
);

    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [PW-1:0] PhaseMax = PW'(DECIM - 1);
    localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);
    localparam logic signed [16:0] RoundAdd = 17'sd1 <<< (SHIFT - 1);

    logic [PW-1:0]        phase_q, phase_d;
    logic [7:0]           stage_data_q, stage_data_d;
    logic                 stage_valid_q, stage_valid_d;
    logic [7:0]           mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 overflow_q, overflow_d, sat_q, sat_d;

    logic                 keep, push, pop, full, drop, sat_now;
    logic signed [16:0]   ext, rounded, shifted;
    logic [7:0]           clamped;

    always_comb begin
        ext     = {y_in[15], y_in};
        rounded = ext + RoundAdd;
        shifted = rounded >>> SHIFT;
        clamped = shifted[7:0];
        sat_now = 1'b0;
        if (shifted > 17'sd127) begin
            clamped = 8'h7f;
            sat_now = 1'b1;
        end else if (shifted < -17'sd128) begin
            clamped = 8'h80;
            sat_now = 1'b1;
        end
    end

    assign keep      = in_en && (phase_q == '0);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign full      = (count_q == CountFull);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot the stage write needs.
    assign push      = stage_valid_q && (!full || pop);
    assign drop      = stage_valid_q && full && !pop;
    assign overflow  = overflow_q;
    assign sat_flag  = sat_q;

    always_comb begin
        phase_d = phase_q;
        if (in_en) begin
            phase_d = (phase_q == PhaseMax) ? '0 : phase_q + 1'b1;
        end
        stage_valid_d = keep;
        stage_data_d  = keep ? clamped : stage_data_q;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q || drop;
        sat_d      = sat_q || (keep && sat_now);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= '0;
            stage_data_q  <= '0;
            stage_valid_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_data_q  <= stage_data_d;
            stage_valid_q <= stage_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            sat_q         <= sat_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= stage_data_q;
        end
    end

endmodule

// File: doc/fir_out_decim.md
# fir_out_decim

Output stage placed directly downstream of the 4-tap FIR filter. It consumes the filter's 16-bit signed output, decimates it by a fixed ratio, then rounds, shifts and saturates each kept sample to 8-bit signed. Results go into a small first-word-fall-through FIFO, read through a valid/ready handshake, so a slow consumer does not stall the filter. Sticky flags report dropped samples and saturation.

## Interface
- DECIM, 4: decimation ratio, ≥1. One of every DECIM accepted input samples is kept.
- SHIFT, 4: right-shift amount for rounding, 1..8.
- DEPTH, 4: FIFO depth in entries, power of two, ≥2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- y_in  input  16  signed FIR output sample.
- in_en  input  1  y_in is a valid sample this cycle.
- out_data  output  8  signed FIFO head; meaningful only while out_valid=1.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.
- sat_flag  output  1  sticky; a kept sample was clipped by saturation.

## Operation
- Phase counter, 0..DECIM-1:
  - Advances only on in_en=1 and wraps from DECIM-1 to 0.
  - The sample arriving with in_en=1 while phase=0 is kept; all others are discarded.
  - With DECIM=1, every in_en sample is kept.
- Arithmetic on a kept sample:
  - Sign-extend to 17 bits.
  - Add 2^(SHIFT-1) (round half up).
  - Arithmetic right shift by SHIFT.
  - Clamp to [-128, 127].
  - If clamping occurred, set sat_flag on the same edge that loads the stage register.
- Stage register: the result is held in a one-entry register (stage_data, stage_valid). On the next edge it is written to the FIFO.
- FIFO write when stage_valid=1:
  - Accepted if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle (pop frees space, push fills it).
  - Otherwise the value is dropped, overflow is set, and FIFO contents are unchanged.
- FIFO read:
  - out_data is the head entry combinationally.
  - A pop occurs when out_valid & out_ready.
  - out_ready while empty has no effect.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Simultaneous push and pop when empty is impossible, because out_valid=0 means no pop occurs.
- Flags:
  - overflow and sat_flag are cleared only by rst.
  - Dropping a sample does not affect the phase counter or the stage register.

## Timing
- Reset values: out_data=0, out_valid=0, overflow=0, sat_flag=0, phase=0, stage_valid=0, FIFO count=0, pointers=0.
- rst assertion mid-operation discards the stage register and all FIFO contents. out_valid drops without waiting for a clock edge.
- Latency: a kept sample on edge E loads the stage register at E and is written to the FIFO at E+1. out_valid rises after E+1 when the FIFO was empty, so the sample is visible 2 cycles after it was presented.
- Throughput: one kept sample per cycle (DECIM=1) is sustained while out_ready=1.
- out_data and out_valid update only on clock edges (and on reset). They hold stable while out_valid=1 and out_ready=0.
- sat_flag asserts 1 cycle after the clipped sample is presented. overflow asserts on the edge where the stage write is rejected.

## Test plan
1. **Reset**: assert rst mid-stream with the FIFO holding 3 entries. Required: out_valid=0, overflow=0 and sat_flag=0 immediately; no data appears after rst is released until new input arrives.
2. **Decimation and rounding** (DECIM=4, SHIFT=4, out_ready=1): in_en=1 with y_in = 24, 100, 200, 300, -24, 5, 5, 5. Required: exactly two outputs, 2 then -1, the first 2 cycles after y_in=24 is applied; sat_flag stays 0.
3. **Saturation**: kept samples y_in = 32767, then -32768. Required: out_data = 127, then -128; sat_flag=1 from 1 cycle after the first sample onward.
4. **Gated input**: in_en toggling 1,0,1,0 with DECIM=2. Required: the phase advances only on in_en=1 and every second enabled sample is output.
5. **Backpressure and overflow** (DECIM=1, DEPTH=4, out_ready=0): push 6 samples with values 16, 32, 48, 64, 80, 96 (SHIFT=4). Required: the FIFO holds 1, 2, 3, 4; the 5th write sets overflow=1; then out_ready=1 drains 1, 2, 3, 4 in order and out_valid falls.
6. **Full with simultaneous pop**: the FIFO is full and out_ready=1 on the same cycle a new stage write arrives. Required: the write is accepted, count stays 4, overflow stays 0, and order is preserved.
